// File: rtl/axi_lite_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : axi_lite_pkg                                           |
// | Description : Response codes, FSM state types and a sizing helper    |
// |               shared by the AXI4-Lite register slave.                |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package axi_lite_pkg;

    // Response codes; the users cast these to the configured response width
    localparam int RESP_OKAY   = 0;
    localparam int RESP_SLVERR = 2;

    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_WAIT_DATA = 2'd1,
        W_WAIT_ADDR = 2'd2,
        W_RESP      = 2'd3
    } write_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } read_state_t;

    // Width of a register index; at least one bit so a single-register
    // configuration still has a legal vector
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_addr_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : axi_lite_addr_decode                                   |
// | Description : Byte address to register index decode with hit flag.   |
// |               Misaligned, below-base and past-end addresses miss.    |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module axi_lite_addr_decode
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REGS   = 4,
    parameter int BASE_ADDR  = 0
) (
    input  logic [ADDR_WIDTH-1:0]            addr,
    output logic                             hit,
    output logic [idx_width(NUM_REGS)-1:0]   index
);

    localparam int C_IDX_W = idx_width(NUM_REGS);

    logic [ADDR_WIDTH-1:0] w_offset;
    logic [ADDR_WIDTH-1:0] w_word;

    // Word offset from the base; only meaningful when addr >= base
    always_comb begin
        w_offset = addr - ADDR_WIDTH'(BASE_ADDR);
        w_word   = w_offset >> 2;
        hit      = (addr[1:0] == 2'b00)
                && (addr >= ADDR_WIDTH'(BASE_ADDR))
                && (w_word < ADDR_WIDTH'(NUM_REGS));
        index    = w_word[C_IDX_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/axi_lite_reg_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : axi_lite_reg_slave                                     |
// | Description : AXI4-Lite responder with a small RW register file,     |
// |               byte strobes, SLVERR on bad addresses, exported        |
// |               register contents and per-register write pulses.       |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module axi_lite_reg_slave
    import axi_lite_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    RESP_WIDTH  = 3,
    parameter int                    NUM_REGS    = 4,
    parameter int                    BASE_ADDR   = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           s0_axi_aclk,
    input  logic                           s0_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]          s0_axi_awaddr,
    input  logic                           s0_axi_awvalid,
    output logic                           s0_axi_awready,
    input  logic [DATA_WIDTH-1:0]          s0_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s0_axi_wstrb,
    input  logic                           s0_axi_wvalid,
    output logic                           s0_axi_wready,
    output logic [RESP_WIDTH-1:0]          s0_axi_bresp,
    output logic                           s0_axi_bvalid,
    input  logic                           s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          s0_axi_araddr,
    input  logic                           s0_axi_arvalid,
    output logic                           s0_axi_arready,
    output logic [DATA_WIDTH-1:0]          s0_axi_rdata,
    output logic [RESP_WIDTH-1:0]          s0_axi_rresp,
    output logic                           s0_axi_rvalid,
    input  logic                           s0_axi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int                    C_STRB_W = DATA_WIDTH / 8;
    localparam int                    C_IDX_W  = idx_width(NUM_REGS);
    localparam logic [RESP_WIDTH-1:0] C_OKAY   = RESP_WIDTH'(RESP_OKAY);
    localparam logic [RESP_WIDTH-1:0] C_SLVERR = RESP_WIDTH'(RESP_SLVERR);

    // Register file
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   r_wr_pulse;

    // Write channel state
    write_state_t          r_wstate, w_wstate_nx;
    logic                  r_awready, w_awready_nx;
    logic                  r_wready, w_wready_nx;
    logic                  r_bvalid, w_bvalid_nx;
    logic [RESP_WIDTH-1:0] r_bresp, w_bresp_nx;
    logic [ADDR_WIDTH-1:0] r_awaddr, w_awaddr_nx;
    logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nx;
    logic [C_STRB_W-1:0]   r_wstrb, w_wstrb_nx;
    logic                  w_do_write;

    // Read channel state
    read_state_t           r_rstate, w_rstate_nx;
    logic                  r_arready, w_arready_nx;
    logic                  r_rvalid, w_rvalid_nx;
    logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nx;
    logic [RESP_WIDTH-1:0] r_rresp, w_rresp_nx;

    // Effective write operands: latched half or live bus half
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [C_STRB_W-1:0]   w_wr_strb;
    logic                  w_wr_hit;
    logic [C_IDX_W-1:0]    w_wr_idx;
    logic                  w_rd_hit;
    logic [C_IDX_W-1:0]    w_rd_idx;

    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

    assign w_aw_hs = s0_axi_awvalid & r_awready;
    assign w_w_hs  = s0_axi_wvalid  & r_wready;
    assign w_b_hs  = r_bvalid       & s0_axi_bready;
    assign w_ar_hs = s0_axi_arvalid & r_arready;
    assign w_r_hs  = r_rvalid       & s0_axi_rready;

    assign w_wr_addr = (r_wstate == W_WAIT_DATA) ? r_awaddr : s0_axi_awaddr;
    assign w_wr_data = (r_wstate == W_WAIT_ADDR) ? r_wdata  : s0_axi_wdata;
    assign w_wr_strb = (r_wstate == W_WAIT_ADDR) ? r_wstrb  : s0_axi_wstrb;

    axi_lite_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .BASE_ADDR  (BASE_ADDR)
    ) u_aw_decode (
        .addr  (w_wr_addr),
        .hit   (w_wr_hit),
        .index (w_wr_idx)
    );

    axi_lite_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .BASE_ADDR  (BASE_ADDR)
    ) u_ar_decode (
        .addr  (s0_axi_araddr),
        .hit   (w_rd_hit),
        .index (w_rd_idx)
    );

    // Write FSM next state; the ready flags reopen in idle so they rise
    // on the first clock after reset
    always_comb begin
        w_wstate_nx  = r_wstate;
        w_awready_nx = r_awready;
        w_wready_nx  = r_wready;
        w_bvalid_nx  = r_bvalid;
        w_bresp_nx   = r_bresp;
        w_awaddr_nx  = r_awaddr;
        w_wdata_nx   = r_wdata;
        w_wstrb_nx   = r_wstrb;
        w_do_write   = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                w_awready_nx = 1'b1;
                w_wready_nx  = 1'b1;
                if (w_aw_hs && w_w_hs) begin
                    w_do_write = 1'b1;
                end else if (w_aw_hs) begin
                    w_awaddr_nx  = s0_axi_awaddr;
                    w_awready_nx = 1'b0;
                    w_wstate_nx  = W_WAIT_DATA;
                end else if (w_w_hs) begin
                    w_wdata_nx  = s0_axi_wdata;
                    w_wstrb_nx  = s0_axi_wstrb;
                    w_wready_nx = 1'b0;
                    w_wstate_nx = W_WAIT_ADDR;
                end
            end
            W_WAIT_DATA: begin
                w_wready_nx = 1'b1;
                w_do_write  = w_w_hs;
            end
            W_WAIT_ADDR: begin
                w_awready_nx = 1'b1;
                w_do_write   = w_aw_hs;
            end
            W_RESP: begin
                if (w_b_hs) begin
                    w_bvalid_nx  = 1'b0;
                    w_awready_nx = 1'b1;
                    w_wready_nx  = 1'b1;
                    w_wstate_nx  = W_IDLE;
                end
            end
            default: w_wstate_nx = W_IDLE;
        endcase
        if (w_do_write) begin
            w_bvalid_nx  = 1'b1;
            w_bresp_nx   = w_wr_hit ? C_OKAY : C_SLVERR;
            w_awready_nx = 1'b0;
            w_wready_nx  = 1'b0;
            w_wstate_nx  = W_RESP;
        end
    end

    // Write FSM state and registered channel outputs
    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= '0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            r_wstate  <= w_wstate_nx;
            r_awready <= w_awready_nx;
            r_wready  <= w_wready_nx;
            r_bvalid  <= w_bvalid_nx;
            r_bresp   <= w_bresp_nx;
            r_awaddr  <= w_awaddr_nx;
            r_wdata   <= w_wdata_nx;
            r_wstrb   <= w_wstrb_nx;
        end
    end

    // Register storage: byte-strobe merge and single-cycle write pulse
    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= RESET_VALUE;
            end
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (w_do_write && w_wr_hit) begin
                r_wr_pulse[w_wr_idx] <= 1'b1;
                for (int b = 0; b < C_STRB_W; b++) begin
                    if (w_wr_strb[b]) begin
                        r_regs[w_wr_idx][b*8 +: 8] <= w_wr_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Read FSM next state; data is sampled from the pre-write register value
    always_comb begin
        w_rstate_nx  = r_rstate;
        w_arready_nx = r_arready;
        w_rvalid_nx  = r_rvalid;
        w_rdata_nx   = r_rdata;
        w_rresp_nx   = r_rresp;
        case (r_rstate)
            R_IDLE: begin
                w_arready_nx = 1'b1;
                if (w_ar_hs) begin
                    w_rdata_nx   = w_rd_hit ? r_regs[w_rd_idx] : '0;
                    w_rresp_nx   = w_rd_hit ? C_OKAY : C_SLVERR;
                    w_rvalid_nx  = 1'b1;
                    w_arready_nx = 1'b0;
                    w_rstate_nx  = R_DATA;
                end
            end
            R_DATA: begin
                if (w_r_hs) begin
                    w_rvalid_nx  = 1'b0;
                    w_arready_nx = 1'b1;
                    w_rstate_nx  = R_IDLE;
                end
            end
            default: w_rstate_nx = R_IDLE;
        endcase
    end

    // Read FSM state and registered channel outputs
    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= '0;
        end else begin
            r_rstate  <= w_rstate_nx;
            r_arready <= w_arready_nx;
            r_rvalid  <= w_rvalid_nx;
            r_rdata   <= w_rdata_nx;
            r_rresp   <= w_rresp_nx;
        end
    end

    assign s0_axi_awready = r_awready;
    assign s0_axi_wready  = r_wready;
    assign s0_axi_bvalid  = r_bvalid;
    assign s0_axi_bresp   = r_bresp;
    assign s0_axi_arready = r_arready;
    assign s0_axi_rvalid  = r_rvalid;
    assign s0_axi_rdata   = r_rdata;
    assign s0_axi_rresp   = r_rresp;
    assign wr_pulse       = r_wr_pulse;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_reg_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_axi_lite_reg_slave                                  |
// | Description : Self-checking bench: two slaves (base 0 and base 16),  |
// |               directed vector table, corner sequences, random mix    |
// |               against an array-based register model.                 |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_axi_lite_reg_slave;

    logic clk;
    logic rst_n;

    logic [7:0]   awaddr  [2];
    logic         awvalid [2];
    logic         awready [2];
    logic [31:0]  wdata   [2];
    logic [3:0]   wstrb   [2];
    logic         wvalid  [2];
    logic         wready  [2];
    logic [2:0]   bresp   [2];
    logic         bvalid  [2];
    logic         bready  [2];
    logic [7:0]   araddr  [2];
    logic         arvalid [2];
    logic         arready [2];
    logic [31:0]  rdata   [2];
    logic [2:0]   rresp   [2];
    logic         rvalid  [2];
    logic         rready  [2];
    logic [127:0] reg_q   [2];
    logic [3:0]   wr_pulse[2];

    int total = 0;
    int bad   = 0;

    // Behavioural register model: plain words per instance
    logic [31:0] mdl [2][4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    axi_lite_reg_slave #(.BASE_ADDR(0)) dut0 (
        .s0_axi_aclk(clk), .s0_axi_aresetn(rst_n),
        .s0_axi_awaddr(awaddr[0]), .s0_axi_awvalid(awvalid[0]), .s0_axi_awready(awready[0]),
        .s0_axi_wdata(wdata[0]), .s0_axi_wstrb(wstrb[0]), .s0_axi_wvalid(wvalid[0]), .s0_axi_wready(wready[0]),
        .s0_axi_bresp(bresp[0]), .s0_axi_bvalid(bvalid[0]), .s0_axi_bready(bready[0]),
        .s0_axi_araddr(araddr[0]), .s0_axi_arvalid(arvalid[0]), .s0_axi_arready(arready[0]),
        .s0_axi_rdata(rdata[0]), .s0_axi_rresp(rresp[0]), .s0_axi_rvalid(rvalid[0]), .s0_axi_rready(rready[0]),
        .reg_q(reg_q[0]), .wr_pulse(wr_pulse[0])
    );

    axi_lite_reg_slave #(.BASE_ADDR(16)) dut1 (
        .s0_axi_aclk(clk), .s0_axi_aresetn(rst_n),
        .s0_axi_awaddr(awaddr[1]), .s0_axi_awvalid(awvalid[1]), .s0_axi_awready(awready[1]),
        .s0_axi_wdata(wdata[1]), .s0_axi_wstrb(wstrb[1]), .s0_axi_wvalid(wvalid[1]), .s0_axi_wready(wready[1]),
        .s0_axi_bresp(bresp[1]), .s0_axi_bvalid(bvalid[1]), .s0_axi_bready(bready[1]),
        .s0_axi_araddr(araddr[1]), .s0_axi_arvalid(arvalid[1]), .s0_axi_arready(arready[1]),
        .s0_axi_rdata(rdata[1]), .s0_axi_rresp(rresp[1]), .s0_axi_rvalid(rvalid[1]), .s0_axi_rready(rready[1]),
        .reg_q(reg_q[1]), .wr_pulse(wr_pulse[1])
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Address rule: aligned, at/above base, word offset below register count
    function automatic bit mdl_hit(input int i, input int a, output int idx);
        int base;
        base = (i == 0) ? 0 : 16;
        idx  = 0;
        if ((a % 4) != 0 || a < base) return 1'b0;
        idx = (a - base) / 4;
        return idx < 4;
    endfunction

    function automatic logic [127:0] exp_regq(input int i);
        return {mdl[i][3], mdl[i][2], mdl[i][1], mdl[i][0]};
    endfunction

    // Called at a negedge; AW and W are raised after independent delays
    task automatic axi_write(input int i, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, output logic [2:0] resp);
        bit aw_done, w_done, aw_f, w_f, hit;
        int k, idx;
        logic [3:0] exp_pulse;
        aw_done = 0; w_done = 0; k = 0; resp = '1;
        bready[i] = 1'b1;
        while (!(aw_done && w_done)) begin
            if (!aw_done && k >= aw_dly) begin awaddr[i] = a; awvalid[i] = 1'b1; end
            if (!w_done && k >= w_dly) begin wdata[i] = d; wstrb[i] = s; wvalid[i] = 1'b1; end
            if (w_done && !aw_done) check("wready_low_waiting_aw", wready[i], 0);
            aw_f = awvalid[i] && awready[i];
            w_f  = wvalid[i] && wready[i];
            @(negedge clk);
            if (aw_f) begin aw_done = 1; awvalid[i] = 1'b0; end
            if (w_f)  begin w_done  = 1; wvalid[i]  = 1'b0; end
            k++;
            if (k > 40) begin
                check("write_handshake_timeout", 0, 1);
                awvalid[i] = 1'b0; wvalid[i] = 1'b0;
                return;
            end
        end
        hit = mdl_hit(i, a, idx);
        exp_pulse = hit ? 4'(1 << idx) : 4'b0;
        if (hit)
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[i][idx][b*8 +: 8] = d[b*8 +: 8];
        check("bvalid_latency", bvalid[i], 1);
        resp = bresp[i];
        check("wr_pulse", wr_pulse[i], exp_pulse);
        check("reg_q_after_write", reg_q[i], exp_regq(i));
        @(negedge clk);
        check("bvalid_cleared", bvalid[i], 0);
        check("wr_pulse_one_cycle", wr_pulse[i], 0);
        check("aw_w_ready_reopen", {awready[i], wready[i]}, 2'b11);
    endtask

    // Called at a negedge; rready stays low for 'hold' cycles after rvalid
    task automatic axi_read(input int i, input logic [7:0] a, input int hold,
                            output logic [31:0] data, output logic [2:0] resp);
        bit f, hit;
        int k, idx;
        logic [31:0] exp_d;
        k = 0; f = 0; data = '0; resp = '1;
        rready[i] = 1'b0;
        araddr[i] = a; arvalid[i] = 1'b1;
        hit = mdl_hit(i, a, idx);
        exp_d = hit ? mdl[i][idx] : 32'h0;
        while (!f) begin
            f = arready[i];
            @(negedge clk);
            k++;
            if (k > 40) begin
                check("read_handshake_timeout", 0, 1);
                arvalid[i] = 1'b0;
                return;
            end
        end
        arvalid[i] = 1'b0;
        check("rvalid_latency", rvalid[i], 1);
        data = rdata[i];
        resp = rresp[i];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("rvalid_held", rvalid[i], 1);
            check("rdata_held", rdata[i], exp_d);
            check("arready_low_in_data", arready[i], 0);
        end
        rready[i] = 1'b1;
        @(negedge clk);
        check("rvalid_cleared", rvalid[i], 0);
        check("arready_reopen", arready[i], 1);
        rready[i] = 1'b0;
    endtask

    typedef struct {
        int          inst;
        bit          is_wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        int          hold;
        logic [2:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [16];

    initial begin
        logic [2:0]  resp;
        logic [31:0] rd;
        int          ri, ridx;
        logic [7:0]  ra;
        bit          rhit;

        for (int i = 0; i < 2; i++) begin
            awaddr[i] = '0; awvalid[i] = 0; wdata[i] = '0; wstrb[i] = '0; wvalid[i] = 0;
            bready[i] = 1; araddr[i] = '0; arvalid[i] = 0; rready[i] = 0;
            for (int r = 0; r < 4; r++) mdl[i][r] = '0;
        end

        //                 inst wr  addr    data          strb aw w hold resp rdata
        tbl[0]  = '{0, 1, 8'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, 3'd0, 32'h0};
        tbl[1]  = '{0, 1, 8'h00, 32'hAABBCCDD, 4'hF, 0, 0, 0, 3'd0, 32'h0};
        tbl[2]  = '{0, 1, 8'h00, 32'h11223344, 4'h5, 3, 0, 0, 3'd0, 32'h0};
        tbl[3]  = '{0, 0, 8'h00, 32'h0,        4'h0, 0, 0, 0, 3'd0, 32'hAA22CC44};
        tbl[4]  = '{0, 1, 8'h0C, 32'h12345678, 4'hF, 0, 2, 0, 3'd0, 32'h0};
        tbl[5]  = '{0, 0, 8'h0C, 32'h0,        4'h0, 0, 0, 4, 3'd0, 32'h12345678};
        tbl[6]  = '{0, 1, 8'h20, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 3'd2, 32'h0};
        tbl[7]  = '{0, 1, 8'h02, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 3'd2, 32'h0};
        tbl[8]  = '{0, 0, 8'h10, 32'h0,        4'h0, 0, 0, 0, 3'd2, 32'h0};
        tbl[9]  = '{0, 1, 8'h08, 32'hCAFEF00D, 4'h0, 0, 0, 0, 3'd0, 32'h0};
        tbl[10] = '{0, 0, 8'h08, 32'h0,        4'h0, 0, 0, 0, 3'd0, 32'h0};
        tbl[11] = '{0, 0, 8'h04, 32'h0,        4'h0, 0, 0, 1, 3'd0, 32'hDEADBEEF};
        tbl[12] = '{1, 1, 8'h10, 32'h01020304, 4'h3, 0, 0, 0, 3'd0, 32'h0};
        tbl[13] = '{1, 0, 8'h0C, 32'h0,        4'h0, 0, 0, 0, 3'd2, 32'h0};
        tbl[14] = '{1, 0, 8'h10, 32'h0,        4'h0, 0, 0, 0, 3'd0, 32'h00000304};
        tbl[15] = '{1, 0, 8'h20, 32'h0,        4'h0, 0, 0, 0, 3'd2, 32'h0};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_readies", {awready[i], wready[i], arready[i]}, 3'b000);
            check("rst_valids", {bvalid[i], rvalid[i]}, 2'b00);
            check("rst_resp_data", {bresp[i], rresp[i], rdata[i]}, 0);
            check("rst_reg_q", reg_q[i], 0);
            check("rst_wr_pulse", wr_pulse[i], 0);
        end
        rst_n = 1'b1;
        #1 check("ready_low_before_first_clk", {awready[0], arready[0]}, 2'b00);
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            check("ready_after_first_clk", {awready[i], wready[i], arready[i]}, 3'b111);

        // Directed vector table
        for (int v = 0; v < 16; v++) begin
            if (tbl[v].is_wr) begin
                axi_write(tbl[v].inst, tbl[v].addr, tbl[v].data, tbl[v].strb,
                          tbl[v].aw_dly, tbl[v].w_dly, resp);
                check($sformatf("vec%0d_bresp", v), resp, tbl[v].exp_resp);
            end else begin
                axi_read(tbl[v].inst, tbl[v].addr, tbl[v].hold, rd, resp);
                check($sformatf("vec%0d_rresp", v), resp, tbl[v].exp_resp);
                check($sformatf("vec%0d_rdata", v), rd, tbl[v].exp_rdata);
            end
        end

        // Same-edge write and read of one register: read sees the old value
        awaddr[1] = 8'h14; wdata[1] = 32'h55; wstrb[1] = 4'hF; araddr[1] = 8'h14;
        awvalid[1] = 1; wvalid[1] = 1; arvalid[1] = 1; bready[1] = 0; rready[1] = 0;
        check("same_edge_readies", {awready[1], wready[1], arready[1]}, 3'b111);
        @(negedge clk);
        awvalid[1] = 0; wvalid[1] = 0; arvalid[1] = 0;
        mdl[1][1] = 32'h55;
        check("same_edge_bvalid_rvalid", {bvalid[1], rvalid[1]}, 2'b11);
        check("same_edge_rdata_old", rdata[1], 32'h0);
        check("same_edge_reg_q", reg_q[1], exp_regq(1));
        bready[1] = 1; rready[1] = 1;
        @(negedge clk);
        rready[1] = 0;
        axi_read(1, 8'h14, 0, rd, resp);
        check("second_read_new_value", rd, 32'h55);

        // Randomized mix against the model
        for (int n = 0; n < 80; n++) begin
            ri = $urandom_range(0, 1);
            ra = 8'($urandom_range(0, 39));
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            rhit = mdl_hit(ri, ra, ridx);
            if ($urandom_range(0, 1) == 1) begin
                axi_write(ri, ra, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), resp);
                check("rand_bresp", resp, rhit ? 3'd0 : 3'd2);
            end else begin
                axi_read(ri, ra, $urandom_range(0, 2), rd, resp);
                check("rand_rresp", resp, rhit ? 3'd0 : 3'd2);
                check("rand_rdata", rd, rhit ? mdl[ri][ridx] : 32'h0);
            end
        end

        // Reset while both response channels are pending
        bready[0] = 0; rready[0] = 0;
        awaddr[0] = 8'h08; wdata[0] = 32'h0BADF00D; wstrb[0] = 4'hF; awvalid[0] = 1; wvalid[0] = 1;
        araddr[0] = 8'h08; arvalid[0] = 1;
        @(negedge clk);
        awvalid[0] = 0; wvalid[0] = 0; arvalid[0] = 0;
        check("pre_reset_pending", {bvalid[0], rvalid[0]}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_valids", {bvalid[0], rvalid[0]}, 2'b00);
        check("async_reset_reg_q", reg_q[0], 0);
        check("async_reset_readies", {awready[0], arready[0]}, 2'b00);
        for (int i = 0; i < 2; i++) for (int r = 0; r < 4; r++) mdl[i][r] = '0;
        bready[0] = 1;
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("post_reset_ready_low", {awready[0], arready[0]}, 2'b00);
        @(negedge clk);
        check("post_reset_ready_high", {awready[0], arready[0]}, 2'b11);
        axi_read(0, 8'h08, 0, rd, resp);
        check("post_reset_read_resp", resp, 3'd0);
        check("post_reset_read_data", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
